// File: rtl/stereo_cam_pkg.sv
// Shared constants, state type and channel-expansion helpers for the stereo
// camera capture path.
package stereo_cam_pkg;

  localparam int unsigned H_RES_DFLT = 320;
  localparam int unsigned V_RES_DFLT = 240;
  localparam int unsigned FRAME_PIX  = H_RES_DFLT * V_RES_DFLT;

  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

  typedef enum logic [1:0] {
    S_WAIT_VS,
    S_CAPTURE,
    S_DONE
  } cap_state_t;

  // Replicate the top bits into the gap so full-scale maps to 255.
  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

endpackage

// File: rtl/rgb565_to_luma.sv
// Three-stage RGB565 -> 8-bit luma pipeline; bank/address/last tags travel
// alongside the data so the writer can retire pixels in order.
module rgb565_to_luma
  import stereo_cam_pkg::*;
#(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_bank,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_last,
  input  logic [15:0]       in_rgb,
  output logic              out_valid,
  output logic              out_bank,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic [7:0]        out_luma
);

  logic [2:0]        vld;
  logic [2:0]        bank;
  logic [2:0]        last;
  logic [ADDR_W-1:0] addr [3];
  logic [7:0]        r8, g8, b8;
  logic [15:0]       pr, pg, pb;
  logic [7:0]        luma;

  always_ff @(posedge pclk) begin
    if (reset) begin
      vld <= '0;
    end else begin
      vld <= {vld[1:0], in_valid};
    end
  end

  always_ff @(posedge pclk) begin
    bank    <= {bank[1:0], in_bank};
    last    <= {last[1:0], in_last};
    addr[0] <= in_addr;
    addr[1] <= addr[0];
    addr[2] <= addr[1];
    r8      <= expand5(in_rgb[15:11]);
    g8      <= expand6(in_rgb[10:5]);
    b8      <= expand5(in_rgb[4:0]);
    pr      <= {8'd0, COEF_R} * {8'd0, r8};
    pg      <= {8'd0, COEF_G} * {8'd0, g8};
    pb      <= {8'd0, COEF_B} * {8'd0, b8};
    // Coefficients sum to 256, so the 16-bit sum cannot overflow.
    luma    <= 8'((pr + pg + pb) >> 8);
  end

  assign out_valid = vld[2];
  assign out_bank  = bank[2];
  assign out_addr  = addr[2];
  assign out_last  = last[2];
  assign out_luma  = luma;

endmodule

// File: rtl/gray_pingpong_writer.sv
// Writes luma frames into a two-bank buffer and swaps banks on frame
// completion only once the consumer has released its bank.
module gray_pingpong_writer
  import stereo_cam_pkg::*;
#(
  parameter int unsigned H_RES  = H_RES_DFLT,
  parameter int unsigned V_RES  = V_RES_DFLT,
  parameter int unsigned ADDR_W = $clog2(FRAME_PIX)
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              v_sync,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [15:0]       wData,
  input  logic              rd_release,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [7:0]        mem_data,
  output logic              rd_bank,
  output logic              frame_done,
  output logic [7:0]        drop_cnt,
  output logic [7:0]        trunc_cnt
);

  localparam int unsigned       FRAME_LEN = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  cap_state_t        state, state_nx;
  logic              vs_q, vs_fall, vs_rise;
  logic              rd_free;
  logic              admit;
  logic              publish, drop_ev, trunc_ev;
  logic              p_valid, p_bank, p_last;
  logic [ADDR_W-1:0] p_addr;
  logic [7:0]        p_luma;

  assign vs_fall = vs_q & ~v_sync;
  assign vs_rise = ~vs_q & v_sync;
  assign admit   = we && (state == S_CAPTURE) && (32'(wAddr) < FRAME_LEN);

  rgb565_to_luma #(.ADDR_W(ADDR_W)) u_luma (
    .pclk      (pclk),
    .reset     (reset),
    .in_valid  (admit),
    .in_bank   (~rd_bank),
    .in_addr   (wAddr),
    .in_last   (wAddr == LAST_ADDR),
    .in_rgb    (wData),
    .out_valid (p_valid),
    .out_bank  (p_bank),
    .out_addr  (p_addr),
    .out_last  (p_last),
    .out_luma  (p_luma)
  );

  always_comb begin
    state_nx = state;
    publish  = 1'b0;
    drop_ev  = 1'b0;
    trunc_ev = 1'b0;
    unique case (state)
      S_WAIT_VS: if (vs_fall) state_nx = S_CAPTURE;
      S_CAPTURE: begin
        if (p_valid && p_last) begin
          state_nx = S_DONE;
        end else if (vs_rise) begin
          state_nx = S_WAIT_VS;
          trunc_ev = 1'b1;
        end
      end
      S_DONE: begin
        state_nx = S_WAIT_VS;
        // A release arriving in this very cycle still frees the bank.
        if (rd_free || rd_release) publish = 1'b1;
        else                       drop_ev = 1'b1;
      end
      default: state_nx = S_WAIT_VS;
    endcase
  end

  always_ff @(posedge pclk) begin
    vs_q <= v_sync;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state      <= S_WAIT_VS;
      rd_bank    <= 1'b1;
      rd_free    <= 1'b1;
      frame_done <= 1'b0;
      drop_cnt   <= '0;
      trunc_cnt  <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      state      <= state_nx;
      frame_done <= publish;
      if (publish) begin
        rd_bank <= ~rd_bank;
        rd_free <= 1'b0;
      end else if (rd_release) begin
        rd_free <= 1'b1;
      end
      if (drop_ev && drop_cnt != '1)   drop_cnt  <= drop_cnt + 8'd1;
      if (trunc_ev && trunc_cnt != '1) trunc_cnt <= trunc_cnt + 8'd1;
      mem_we <= p_valid;
      if (p_valid) begin
        mem_addr <= {p_bank, p_addr};
        mem_data <= p_luma;
      end
    end
  end

endmodule

// File: tb/tb_gray_pingpong_writer.sv
// Randomized bench for gray_pingpong_writer against a frame-level model
// (small frame geometry keeps multi-frame and saturation scenarios short).
module tb_gray_pingpong_writer;

  localparam int unsigned HR = 16;
  localparam int unsigned VR = 4;
  localparam int unsigned FP = HR * VR;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        v_sync = 1'b1;
  logic        we = 1'b0;
  logic [16:0] wAddr = '0;
  logic [15:0] wData = '0;
  logic        rd_release = 1'b0;
  logic        mem_we;
  logic [17:0] mem_addr;
  logic [7:0]  mem_data;
  logic        rd_bank;
  logic        frame_done;
  logic [7:0]  drop_cnt;
  logic [7:0]  trunc_cnt;

  gray_pingpong_writer #(.H_RES(HR), .V_RES(VR)) dut (
    .pclk       (pclk),
    .reset      (reset),
    .v_sync     (v_sync),
    .we         (we),
    .wAddr      (wAddr),
    .wData      (wData),
    .rd_release (rd_release),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .rd_bank    (rd_bank),
    .frame_done (frame_done),
    .drop_cnt   (drop_cnt),
    .trunc_cnt  (trunc_cnt)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int passed = 0;
  int ncyc = 0;

  typedef struct {
    int          due;
    logic [17:0] addr;
    logic [7:0]  data;
  } exp_t;
  exp_t exp_q[$];

  int writes_b0 = 0;
  int writes_b1 = 0;
  int fd_seen = 0;
  int last_we_cyc = -10;
  bit fd_prev = 1'b0;
  int frame1_base = 0;

  // Frame-level reference state
  bit cap = 1'b0;
  bit m_rd_bank = 1'b1;
  bit m_free = 1'b1;
  int m_drop = 0;
  int m_trunc = 0;
  int m_fd = 0;

  function automatic logic [7:0] luma(input logic [15:0] p);
    int r, g, b;
    r = int'(p[15:11]); r = r * 8 + r / 4;
    g = int'(p[10:5]);  g = g * 4 + g / 16;
    b = int'(p[4:0]);   b = b * 8 + b / 4;
    return 8'((77 * r + 150 * g + 29 * b) / 256);
  endfunction

  always @(negedge pclk) begin
    exp_t e;
    ncyc++;
    if (!reset) begin
      if (mem_we === 1'b1) begin
        if (mem_addr[17]) writes_b1++; else writes_b0++;
        if (mem_addr[16:0] == 17'(FP - 1)) last_we_cyc = ncyc;
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_write: got addr=%h data=%h at cyc %0d, expected no write",
                   mem_addr, mem_data, ncyc);
        end else begin
          e = exp_q.pop_front();
          if (e.due != ncyc || e.addr !== mem_addr || e.data !== mem_data)
            $display("FAIL write: got cyc=%0d addr=%h data=%h, expected cyc=%0d addr=%h data=%h",
                     ncyc, mem_addr, mem_data, e.due, e.addr, e.data);
          else passed++;
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= ncyc) begin
        checks++;
        $display("FAIL missing_write: got mem_we=%b at cyc %0d, expected addr=%h data=%h",
                 mem_we, ncyc, exp_q[0].addr, exp_q[0].data);
        void'(exp_q.pop_front());
      end
      if (frame_done === 1'b1) begin
        fd_seen++;
        checks++;
        if (fd_prev || ncyc != last_we_cyc + 1)
          $display("FAIL frame_done_timing: got pulse at cyc %0d (prev=%b), expected cyc %0d single",
                   ncyc, fd_prev, last_we_cyc + 1);
        else passed++;
      end
      fd_prev = frame_done;
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    we = 1'b0;
    rd_release = 1'b0;
    repeat (n) tick();
  endtask

  task automatic px(input logic [16:0] a, input logic [15:0] d);
    we = 1'b1;
    wAddr = a;
    wData = d;
    if (cap && a < 17'(FP))
      exp_q.push_back('{due: ncyc + 5, addr: {~m_rd_bank, a}, data: luma(d)});
    tick();
  endtask

  task automatic start_frame();
    we = 1'b0;
    v_sync = 1'b1;
    tick();
    v_sync = 1'b0;
    tick();
    cap = 1'b1;
  endtask

  task automatic full_frame(input int from, input bit gaps, input bit junk);
    for (int a = from; a < int'(FP); a++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle(1);
      if (junk && $urandom_range(0, 7) == 0)
        px(17'(FP + $urandom_range(0, 1000)), 16'($urandom));
      px(17'(a), 16'($urandom));
    end
  endtask

  // Called right after the last pixel; the fourth slot is the done cycle.
  task automatic end_frame(input bit rel);
    we = 1'b0;
    repeat (3) tick();
    rd_release = rel;
    tick();
    rd_release = 1'b0;
    repeat (3) tick();
    cap = 1'b0;
    if (m_free || rel) begin
      m_rd_bank = ~m_rd_bank;
      m_free = 1'b0;
      m_fd++;
    end else if (m_drop < 255) begin
      m_drop++;
    end
  endtask

  task automatic truncate();
    we = 1'b0;
    v_sync = 1'b1;
    cap = 1'b0;
    tick();
    if (m_trunc < 255) m_trunc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) tick();
    checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else passed++;
    checks++; if (mem_addr !== 18'd0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else passed++;
    checks++; if (mem_data !== 8'd0) $display("FAIL reset_mem_data: got %h want 0", mem_data); else passed++;
    checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else passed++;
    checks++; if (rd_bank !== 1'b1) $display("FAIL reset_rd_bank: got %b want 1", rd_bank); else passed++;
    checks++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); else passed++;
    checks++; if (trunc_cnt !== 8'd0) $display("FAIL reset_trunc_cnt: got %0d want 0", trunc_cnt); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_wait_vs_ignored();
    int w;
    w = writes_b0 + writes_b1;
    for (int i = 0; i < 6; i++) px(17'(i), 16'($urandom));
    idle(6);
    checks++;
    if (writes_b0 + writes_b1 != w)
      $display("FAIL wait_vs_writes: got %0d writes want 0", writes_b0 + writes_b1 - w);
    else passed++;
  endtask

  task automatic test_colours();
    logic [15:0] col [5];
    logic [7:0]  yv  [5];
    col = '{16'hFFFF, 16'h0000, 16'hF800, 16'h07E0, 16'h001F};
    yv  = '{8'hFF, 8'h00, 8'h4C, 8'h95, 8'h1C};
    frame1_base = writes_b0;
    start_frame();
    for (int i = 0; i < 5; i++) begin
      px(17'(i), col[i]);
      idle(3);
      checks++;
      if (mem_we !== 1'b1 || mem_data !== yv[i] || mem_addr !== 18'(i))
        $display("FAIL colour_%0d: got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                 i, mem_we, mem_addr, mem_data, 18'(i), yv[i]);
      else passed++;
    end
  endtask

  task automatic test_full_frame();
    full_frame(5, 1'b1, 1'b1);
    end_frame(1'b0);
    checks++; if (writes_b0 - frame1_base != int'(FP))
      $display("FAIL frame1_bank0_writes: got %0d want %0d", writes_b0 - frame1_base, FP); else passed++;
    checks++; if (fd_seen != 1) $display("FAIL frame1_done_count: got %0d want 1", fd_seen); else passed++;
    checks++; if (rd_bank !== 1'b0) $display("FAIL frame1_rd_bank: got %b want 0", rd_bank); else passed++;
    checks++; if (drop_cnt !== 8'd0) $display("FAIL frame1_drop: got %0d want 0", drop_cnt); else passed++;
  endtask

  task automatic test_drop_then_release();
    int w1;
    for (int f = 2; f <= 4; f++) begin
      w1 = writes_b1;
      start_frame();
      full_frame(0, 1'b1, 1'b0);
      end_frame(f == 4);
      checks++; if (writes_b1 - w1 != int'(FP))
        $display("FAIL frame%0d_bank1_writes: got %0d want %0d", f, writes_b1 - w1, FP); else passed++;
      checks++; if (drop_cnt !== 8'(m_drop))
        $display("FAIL frame%0d_drop: got %0d want %0d", f, drop_cnt, m_drop); else passed++;
      checks++; if (rd_bank !== m_rd_bank)
        $display("FAIL frame%0d_rd_bank: got %b want %b", f, rd_bank, m_rd_bank); else passed++;
      checks++; if (fd_seen != m_fd)
        $display("FAIL frame%0d_done_count: got %0d want %0d", f, fd_seen, m_fd); else passed++;
    end
  endtask

  task automatic test_truncate();
    start_frame();
    for (int a = 0; a < 40; a++) px(17'(a), 16'($urandom));
    truncate();
    idle(6);
    checks++; if (trunc_cnt !== 8'd1) $display("FAIL trunc_cnt: got %0d want 1", trunc_cnt); else passed++;
    checks++; if (fd_seen != m_fd) $display("FAIL trunc_no_done: got %0d want %0d", fd_seen, m_fd); else passed++;
    checks++; if (rd_bank !== 1'b1) $display("FAIL trunc_rd_bank: got %b want 1", rd_bank); else passed++;
  endtask

  task automatic test_out_of_range();
    int w;
    w = writes_b0 + writes_b1;
    start_frame();
    px(17'(FP), 16'($urandom));
    px(17'h1FFFF, 16'($urandom));
    px(17'(FP + $urandom_range(1, 500)), 16'($urandom));
    truncate();
    idle(6);
    checks++; if (writes_b0 + writes_b1 != w)
      $display("FAIL oor_writes: got %0d want 0", writes_b0 + writes_b1 - w); else passed++;
    checks++; if (trunc_cnt !== 8'(m_trunc))
      $display("FAIL oor_trunc: got %0d want %0d", trunc_cnt, m_trunc); else passed++;
  endtask

  task automatic test_drop_saturate();
    repeat (256) begin
      start_frame();
      full_frame(0, 1'b0, 1'b0);
      end_frame(1'b0);
    end
    checks++; if (drop_cnt !== 8'd255) $display("FAIL drop_saturate: got %0d want 255", drop_cnt); else passed++;
    checks++; if (rd_bank !== m_rd_bank)
      $display("FAIL drop_sat_rd_bank: got %b want %b", rd_bank, m_rd_bank); else passed++;
  endtask

  task automatic test_release_between();
    rd_release = 1'b1;
    tick();
    tick();
    rd_release = 1'b0;
    m_free = 1'b1;
    start_frame();
    full_frame(0, 1'b1, 1'b1);
    end_frame(1'b0);
    checks++; if (rd_bank !== 1'b0) $display("FAIL release_swap_rd_bank: got %b want 0", rd_bank); else passed++;
    checks++; if (fd_seen != m_fd) $display("FAIL release_done_count: got %0d want %0d", fd_seen, m_fd); else passed++;
    checks++; if (drop_cnt !== 8'd255) $display("FAIL release_drop_hold: got %0d want 255", drop_cnt); else passed++;
  endtask

  task automatic test_trunc_saturate();
    repeat (256) begin
      start_frame();
      px(17'd0, 16'($urandom));
      truncate();
    end
    idle(6);
    checks++; if (trunc_cnt !== 8'd255) $display("FAIL trunc_saturate: got %0d want 255", trunc_cnt); else passed++;
  endtask

  task automatic test_reset_midframe();
    int w;
    start_frame();
    px(17'd0, 16'($urandom));
    px(17'd1, 16'($urandom));
    px(17'd2, 16'($urandom));
    we = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    tick();
    checks++; if (mem_we !== 1'b0) $display("FAIL midreset_mem_we: got %b want 0", mem_we); else passed++;
    checks++; if (mem_addr !== 18'd0 || mem_data !== 8'd0)
      $display("FAIL midreset_mem_bus: got addr=%h data=%h want 0", mem_addr, mem_data); else passed++;
    checks++; if (rd_bank !== 1'b1) $display("FAIL midreset_rd_bank: got %b want 1", rd_bank); else passed++;
    checks++; if (drop_cnt !== 8'd0 || trunc_cnt !== 8'd0 || frame_done !== 1'b0)
      $display("FAIL midreset_counters: got drop=%0d trunc=%0d fd=%b want 0", drop_cnt, trunc_cnt, frame_done);
    else passed++;
    reset = 1'b0;
    cap = 1'b0; m_rd_bank = 1'b1; m_free = 1'b1; m_drop = 0; m_trunc = 0;
    w = writes_b0 + writes_b1;
    for (int i = 3; i < 9; i++) px(17'(i), 16'($urandom));
    idle(6);
    checks++; if (writes_b0 + writes_b1 != w)
      $display("FAIL midreset_no_capture: got %0d writes want 0", writes_b0 + writes_b1 - w); else passed++;
    w = writes_b0;
    start_frame();
    for (int i = 0; i < 8; i++) px(17'(i), 16'($urandom));
    idle(6);
    checks++; if (writes_b0 - w != 8)
      $display("FAIL midreset_resume_bank0: got %0d writes want 8", writes_b0 - w); else passed++;
  endtask

  initial begin
    test_reset();
    test_wait_vs_ignored();
    test_colours();
    test_full_frame();
    test_drop_then_release();
    test_truncate();
    test_out_of_range();
    test_drop_saturate();
    test_release_between();
    test_trunc_saturate();
    test_reset_midframe();
    idle(10);
    checks++;
    if (exp_q.size() != 0) $display("FAIL drain: got %0d pending writes want 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
